// File: rtl/nv_evt_rx_pkg.sv
// Shared constants and helpers for the toggle-event receiver.
// Optional overflow reporting is controlled by NV_EVT_RX_OVF_EN in the top level.
package nv_evt_rx_pkg;

    localparam int CNT_W_DEF = 4;

    // Largest value a counter of width w can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/nv_evt_edge_det.sv
// Turns each level change of an already-synchronized toggle into a one-cycle pulse.
// Latency: combinational pulse in the cycle the new level arrives; no backpressure.
module nv_evt_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_tgl,
    output logic tgl_edge
);

    logic tgl_q;

    // Resetting to 0 means a source parked at 0 produces no spurious edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= sync_tgl;
        end
    end

    assign tgl_edge = sync_tgl ^ tgl_q;

endmodule

// File: rtl/nv_evt_toggle_rx.sv
// Counts toggle events, hands them out with a valid/ready handshake, and acks each pop.
// Latency: edge visible one cycle later; consumer stalls via evt_ready, full drops edges.
// Optional sticky overflow flag enabled with macro NV_EVT_RX_OVF_EN.
module nv_evt_toggle_rx
    import nv_evt_rx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             sync_tgl,
    input  logic             evt_clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ack_tgl,
    output logic             ovf_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic tgl_edge;
    logic pop;
    logic full;

    nv_evt_edge_det u_edge_det (
        .clk      (nvdla_core_clk),
        .rst_n    (nvdla_core_rstn),
        .sync_tgl (sync_tgl),
        .tgl_edge (tgl_edge)
    );

    assign evt_valid = (evt_cnt != '0);
    assign pop       = evt_valid & evt_ready;
    assign full      = (evt_cnt == CNT_MAX);

    // Clear wins over any same-cycle edge or pop; a simultaneous edge and pop cancel out.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            evt_cnt <= '0;
        end else if (evt_clr) begin
            evt_cnt <= '0;
        end else if (tgl_edge && !pop && !full) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end else if (pop && !tgl_edge) begin
            evt_cnt <= evt_cnt - CNT_W'(1);
        end
    end

    // The ack path keeps tracking pops even during a clear so the source never loses sync.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ack_tgl <= 1'b0;
        end else if (pop) begin
            ack_tgl <= ~ack_tgl;
        end
    end

`ifdef NV_EVT_RX_OVF_EN
    logic drop;
    assign drop = tgl_edge & ~pop & full;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ovf_err <= 1'b0;
        end else if (evt_clr) begin
            ovf_err <= 1'b0;
        end else if (drop) begin
            ovf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
`endif

endmodule
